// File: rtl/serial_arith_pkg.sv
// Shared constants for the sequential-arithmetic library.
// Default digit geometry for digit-serial operators.
package serial_arith_pkg;

    localparam int DIGIT_W_DEF     = 4;
    localparam int WORD_DIGITS_DEF = 8;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full adder built from logic gates only.
// One cell of the ripple chain inside serial_add_sub_digit.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (w_p & cin);

endmodule

// File: rtl/serial_add_sub_digit.sv
// Digit-serial adder/subtractor, LS digit first, DIGIT_W bits per beat.
// Reports unsigned carry/borrow and signed overflow on each word's final digit.
module serial_add_sub_digit
    import serial_arith_pkg::*;
#(
    parameter int DIGIT_W     = DIGIT_W_DEF,
    parameter int WORD_DIGITS = WORD_DIGITS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_sub,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               out_valid,
    output logic [DIGIT_W-1:0] sum,
    output logic               out_last,
    output logic               carry_out,
    output logic               overflow
);

    localparam int CNT_W = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
    // Incremented position carries one extra bit so the word length itself is representable.
    localparam logic [CNT_W:0] WORD_CNT = (CNT_W + 1)'(WORD_DIGITS);

    // Gate-level incrementer for the digit counter (half-adder ripple).
    function automatic logic [CNT_W:0] f_inc(input logic [CNT_W-1:0] v);
        logic cy;
        f_inc = '0;
        cy    = 1'b1;
        for (int i = 0; i < CNT_W; i++) begin
            f_inc[i] = v[i] ^ cy;
            cy       = v[i] & cy;
        end
        f_inc[CNT_W] = cy;
    endfunction

    logic [CNT_W-1:0]   r_pos;
    logic               r_c;
    logic               r_sub;

    logic               r_vld_p1;
    logic [DIGIT_W-1:0] r_sum_p1;
    logic               r_last_p1;
    logic               r_carry_p1;
    logic               r_ovf_p1;

    logic               w_first;
    logic               w_last;
    logic               w_m;
    logic [DIGIT_W-1:0] w_bx;
    logic [DIGIT_W:0]   w_k;
    logic [DIGIT_W-1:0] w_s;
    logic [CNT_W:0]     w_pos_inc;

    assign w_first   = (r_pos == '0);
    assign w_pos_inc = f_inc(r_pos);
    assign w_last    = (w_pos_inc == WORD_CNT);

    // Mode is live on digit 0 and latched afterwards; subtract inverts B and seeds carry 1.
    assign w_m    = w_first ? in_sub : r_sub;
    assign w_bx   = b ^ {DIGIT_W{w_m}};
    assign w_k[0] = w_first ? w_m : r_c;

    for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_ripple
        full_adder_bit u_fa (
            .a    (a[gi]),
            .b    (w_bx[gi]),
            .cin  (w_k[gi]),
            .s    (w_s[gi]),
            .cout (w_k[gi+1])
        );
    end

    // Stage p0 -> p1: digit state update and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos      <= '0;
            r_c        <= 1'b0;
            r_sub      <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_sum_p1   <= '0;
            r_last_p1  <= 1'b0;
            r_carry_p1 <= 1'b0;
            r_ovf_p1   <= 1'b0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_pos      <= w_last ? '0 : w_pos_inc[CNT_W-1:0];
                r_c        <= w_k[DIGIT_W];
                if (w_first) begin
                    r_sub <= in_sub;
                end
                r_sum_p1   <= w_s;
                r_last_p1  <= w_last;
                r_carry_p1 <= w_last & w_k[DIGIT_W];
                r_ovf_p1   <= w_last & (w_k[DIGIT_W] ^ w_k[DIGIT_W-1]);
            end
        end
    end

    assign out_valid = r_vld_p1;
    assign sum       = r_sum_p1;
    assign out_last  = r_last_p1;
    assign carry_out = r_carry_p1;
    assign overflow  = r_ovf_p1;

endmodule

// File: tb/tb_serial_add_sub_digit.sv
// Directed bench for serial_add_sub_digit with 4-bit digits and 2-digit words.
module tb_serial_add_sub_digit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_sub;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic [3:0] sum;
    logic       out_last;
    logic       carry_out;
    logic       overflow;

    int n_checks;
    int n_errors;

    serial_add_sub_digit #(.DIGIT_W(4), .WORD_DIGITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sub    (in_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .sum       (sum),
        .out_last  (out_last),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check every output after a beat or idle cycle.
    task automatic chk_all(input string tag, input logic vld, input logic [3:0] s,
                           input logic last, input logic cy, input logic ov);
        chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, vld});
        chk({tag, ".sum"},   {4'd0, sum},       {4'd0, s});
        chk({tag, ".last"},  {7'd0, out_last},  {7'd0, last});
        chk({tag, ".carry"}, {7'd0, carry_out}, {7'd0, cy});
        chk({tag, ".ovf"},   {7'd0, overflow},  {7'd0, ov});
    endtask

    task automatic beat(input logic [3:0] da, input logic [3:0] db, input logic sub);
        a        = da;
        b        = db;
        in_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a        = 4'h0;
        b        = 4'h0;
        in_sub   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sub   = 1'b0;
        a        = 4'h0;
        b        = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // 0x3A + 0x0C = 0x46
        beat(4'hA, 4'hC, 1'b0);
        chk_all("add3A_d0", 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        beat(4'h3, 4'h0, 1'b0);
        chk_all("add3A_d1", 1'b1, 4'h4, 1'b1, 1'b0, 1'b0);

        // 0xFF + 0x01 = 0x00, carry out
        beat(4'hF, 4'h1, 1'b0);
        chk_all("addFF_d0", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        beat(4'hF, 4'h0, 1'b0);
        chk_all("addFF_d1", 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);

        // 0x7F + 0x01 = 0x80, signed overflow; must not inherit the previous carry
        beat(4'hF, 4'h1, 1'b0);
        chk_all("add7F_d0", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        beat(4'h7, 4'h0, 1'b0);
        chk_all("add7F_d1", 1'b1, 4'h8, 1'b1, 1'b0, 1'b1);

        // 0x05 - 0x07 = 0xFE, borrow; mode comes from digit 0 only
        beat(4'h5, 4'h7, 1'b1);
        chk_all("sub_d0", 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
        beat(4'h0, 4'h0, 1'b0);
        chk_all("sub_d1", 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);

        // 0x3A + 0x0C with three idle cycles between digits
        beat(4'hA, 4'hC, 1'b0);
        chk_all("gap_d0", 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        idle();
        chk_all("gap_idle0", 1'b0, 4'h6, 1'b0, 1'b0, 1'b0);
        idle();
        chk_all("gap_idle1", 1'b0, 4'h6, 1'b0, 1'b0, 1'b0);
        idle();
        chk_all("gap_idle2", 1'b0, 4'h6, 1'b0, 1'b0, 1'b0);
        beat(4'h3, 4'h0, 1'b0);
        chk_all("gap_d1", 1'b1, 4'h4, 1'b1, 1'b0, 1'b0);
        idle();
        chk_all("gap_after", 1'b0, 4'h4, 1'b1, 1'b0, 1'b0);

        // Reset mid-word; a beat presented during reset is dropped
        beat(4'hF, 4'h1, 1'b0);
        chk_all("rstmid_d0", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sub   = 1'b1;
        a        = 4'hF;
        b        = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("rstmid_rst", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        beat(4'hA, 4'hC, 1'b0);
        chk_all("rstmid_w_d0", 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        beat(4'h3, 4'h0, 1'b0);
        chk_all("rstmid_w_d1", 1'b1, 4'h4, 1'b1, 1'b0, 1'b0);
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
